// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 luma capture path: state encoding and default geometry.
package ov7670_pkg;

    localparam int ADDR_W    = 16;
    localparam int DEF_IMG_W = 320;
    localparam int DEF_IMG_H = 200;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_VS    = 2'd1,
        ST_WAIT_FRAME = 2'd2,
        ST_CAPTURE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/ov7670_capture_cam_sync.sv
// Brings the camera bus into the dclk domain. All 11 bits share one 2-FF chain so data
// stays aligned with PCLK; a third PCLK flop yields a one-cycle pulse per PCLK rise.
module cam_sync (
    input  logic       dclk,
    input  logic       rst,
    input  logic       i_pclk,
    input  logic       i_vsync,
    input  logic       i_href,
    input  logic [7:0] i_d,
    output logic       o_pe,
    output logic       o_vs,
    output logic       o_hr,
    output logic [7:0] o_d
);

    logic [10:0] r_s1;
    logic [10:0] r_s2;
    logic        r_s3;

    // Outputs are registered so pe, vs, hr and d always describe the same PCLK rise.
    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= 1'b0;
            o_pe <= 1'b0;
            o_vs <= 1'b0;
            o_hr <= 1'b0;
            o_d  <= '0;
        end else begin
            r_s1 <= {i_pclk, i_vsync, i_href, i_d};
            r_s2 <= r_s1;
            r_s3 <= r_s2[10];
            o_pe <= r_s2[10] & ~r_s3;
            o_vs <= r_s2[9];
            o_hr <= r_s2[8];
            o_d  <= r_s2[7:0];
        end
    end

endmodule

// File: rtl/ov7670_capture.sv
// Writer side of the greyscale frame buffer: keeps the Y byte of each YUYV pixel and
// writes it to the image RAM at line*IMG_W + col, one frame per VSYNC period.
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int Y_PHASE = 0
) (
    input  logic              dclk,
    input  logic              rst,
    input  logic              capture_en,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_d,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              busy,
    output logic [7:0]        frame_cnt,
    output cap_state_t        dbg_state
);

    localparam int                COL_W    = $clog2(IMG_W + 1);
    localparam int                LINE_W   = $clog2(IMG_H + 1);
    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(IMG_W);
    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(IMG_H);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic              PH_Y     = (Y_PHASE != 0);

    logic       w_pe;
    logic       w_vs;
    logic       w_hr;
    logic [7:0] w_d;

    cap_state_t        r_state;
    logic [COL_W-1:0]  r_col;
    logic [LINE_W-1:0] r_line;
    logic [ADDR_W-1:0] r_row_base;
    logic              r_phase;
    logic              r_hr_prev;

    cam_sync u_sync (
        .dclk    (dclk),
        .rst     (rst),
        .i_pclk  (cam_pclk),
        .i_vsync (cam_vsync),
        .i_href  (cam_href),
        .i_d     (cam_d),
        .o_pe    (w_pe),
        .o_vs    (w_vs),
        .o_hr    (w_hr),
        .o_d     (w_d)
    );

    assign dbg_state = r_state;

    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_col      <= '0;
            r_line     <= '0;
            r_row_base <= '0;
            r_phase    <= 1'b0;
            r_hr_prev  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (capture_en) r_state <= ST_WAIT_VS;
                end
                ST_WAIT_VS: begin
                    if (w_pe && w_vs) r_state <= ST_WAIT_FRAME;
                end
                ST_WAIT_FRAME: begin
                    if (w_pe && !w_vs) begin
                        r_state    <= ST_CAPTURE;
                        busy       <= 1'b1;
                        r_col      <= '0;
                        r_line     <= '0;
                        r_row_base <= '0;
                        r_phase    <= 1'b0;
                        r_hr_prev  <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (w_pe) begin
                        r_hr_prev <= w_hr;
                        // VSYNC rise ends the frame even mid-line; it beats a coincident line end.
                        if (w_vs) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 8'd1;
                            busy       <= 1'b0;
                            r_col      <= '0;
                            r_line     <= '0;
                            r_row_base <= '0;
                            r_phase    <= 1'b0;
                            r_hr_prev  <= 1'b0;
                            r_state    <= capture_en ? ST_WAIT_FRAME : ST_IDLE;
                        end else if (w_hr) begin
                            if (r_phase == PH_Y && r_col < COL_MAX && r_line < LINE_MAX) begin
                                wr_en   <= 1'b1;
                                wr_addr <= r_row_base + ADDR_W'(r_col);
                                wr_data <= w_d;
                            end
                            r_phase <= ~r_phase;
                            if (r_phase && r_col < COL_MAX) r_col <= r_col + COL_W'(1);
                        end else if (r_hr_prev) begin
                            // Empty lines do not consume a RAM row; row_base replaces a multiplier.
                            if (r_col != '0 && r_line < LINE_MAX) begin
                                r_line     <= r_line + LINE_W'(1);
                                r_row_base <= r_row_base + ROW_STEP;
                            end
                            r_col   <= '0;
                            r_phase <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture with a 4x3 image and PCLK at dclk/4.
module tb_ov7670_capture;
    import ov7670_pkg::*;

    logic        dclk = 1'b0;
    logic        rst = 1'b0;
    logic        capture_en = 1'b0;
    logic        cam_pclk = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_d = '0;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        frame_done;
    logic        busy;
    logic [7:0]  frame_cnt;
    cap_state_t  dbg_state;

    int          n_checks = 0;
    int          n_err = 0;
    int          fd_cnt = 0;
    logic [7:0]  exp_frames = '0;
    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];

    ov7670_capture #(.IMG_W(4), .IMG_H(3), .Y_PHASE(0)) dut (
        .dclk       (dclk),
        .rst        (rst),
        .capture_en (capture_en),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_d      (cam_d),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .dbg_state  (dbg_state)
    );

    always #5 dclk = ~dclk;

    always @(negedge dclk) begin
        if (wr_en) obs_q.push_back({wr_addr, wr_data});
        if (frame_done) fd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic vs, input logic hr, input logic [7:0] d);
        @(negedge dclk);
        cam_vsync = vs;
        cam_href  = hr;
        cam_d     = d;
        cam_pclk  = 1'b0;
        @(negedge dclk);
        @(negedge dclk);
        cam_pclk = 1'b1;
        @(negedge dclk);
    endtask

    task automatic send_line(input int npx, input logic [7:0] ybase);
        for (int p = 0; p < npx; p++) begin
            tick(1'b0, 1'b1, ybase + 8'(p));
            tick(1'b0, 1'b1, 8'hAA);
        end
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_start();
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_end();
        tick(1'b1, 1'b0, 8'h00);
    endtask

    task automatic exp_wr(input logic [15:0] addr, input logic [7:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic verify(input string tag, input int exp_fd);
        logic [23:0] o;
        logic [23:0] e;
        repeat (8) @(negedge dclk);
        check({tag, " n_wr"}, obs_q.size(), exp_q.size());
        check({tag, " n_fd"}, fd_cnt, exp_fd);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, " wr"}, o, e);
        end
        obs_q.delete();
        exp_q.delete();
        fd_cnt = 0;
    endtask

    initial begin
        // Test 1: reset values, then asynchronous reset in the middle of a line.
        repeat (3) @(negedge dclk);
        check("rst wr_en", wr_en, 0);
        check("rst wr_addr", wr_addr, 0);
        check("rst wr_data", wr_data, 0);
        check("rst frame_done", frame_done, 0);
        check("rst busy", busy, 0);
        check("rst frame_cnt", frame_cnt, 0);
        rst = 1'b1;
        capture_en = 1'b1;
        frame_start();
        tick(1'b0, 1'b1, 8'h10);
        tick(1'b0, 1'b1, 8'hAA);
        tick(1'b0, 1'b1, 8'h11);
        tick(1'b0, 1'b1, 8'hAA);
        exp_wr(16'd0, 8'h10);
        exp_wr(16'd1, 8'h11);
        verify("t1_pre", 0);
        check("t1 busy_before", busy, 1);
        check("t1 addr_before", wr_addr, 1);
        @(posedge dclk);
        #2 rst = 1'b0;
        #1;
        check("t1 async wr_addr", wr_addr, 0);
        check("t1 async wr_data", wr_data, 0);
        check("t1 async busy", busy, 0);
        check("t1 async state", dbg_state, ST_IDLE);
        @(negedge dclk);
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        repeat (2) @(negedge dclk);
        rst = 1'b1;
        send_line(4, 8'h50);
        verify("t1_post", 0);

        // Test 2: full 3x4 frame.
        frame_start();
        send_line(4, 8'h10);
        send_line(4, 8'h14);
        send_line(4, 8'h18);
        frame_end();
        for (int i = 0; i < 12; i++) exp_wr(16'(i), 8'h10 + 8'(i));
        verify("t2", 1);
        exp_frames++;
        check("t2 frame_cnt", frame_cnt, exp_frames);

        // Test 3: over-long line is clipped.
        frame_start();
        send_line(6, 8'h40);
        send_line(4, 8'h50);
        send_line(4, 8'h60);
        frame_end();
        for (int i = 0; i < 4; i++) begin
            exp_wr(16'(i), 8'h40 + 8'(i));
        end
        for (int i = 0; i < 4; i++) exp_wr(16'(4 + i), 8'h50 + 8'(i));
        for (int i = 0; i < 4; i++) exp_wr(16'(8 + i), 8'h60 + 8'(i));
        verify("t3", 1);
        exp_frames++;

        // Test 4: short line leaves a gap in the row.
        frame_start();
        send_line(2, 8'h20);
        send_line(4, 8'h30);
        frame_end();
        exp_wr(16'd0, 8'h20);
        exp_wr(16'd1, 8'h21);
        for (int i = 0; i < 4; i++) exp_wr(16'(4 + i), 8'h30 + 8'(i));
        verify("t4", 1);
        exp_frames++;

        // Test 5: extra lines are dropped.
        frame_start();
        for (int l = 0; l < 5; l++) send_line(4, 8'h70 + 8'(4 * l));
        frame_end();
        for (int i = 0; i < 12; i++) exp_wr(16'(i), 8'h70 + 8'(i));
        verify("t5", 1);
        exp_frames++;
        check("t5 frame_cnt", frame_cnt, exp_frames);

        // Test 6: capture_en drops mid-frame; frame completes, then capture stops.
        frame_start();
        send_line(4, 8'h80);
        capture_en = 1'b0;
        send_line(4, 8'h84);
        send_line(4, 8'h88);
        frame_end();
        for (int i = 0; i < 12; i++) exp_wr(16'(i), 8'h80 + 8'(i));
        verify("t6", 1);
        exp_frames++;
        check("t6 busy", busy, 0);
        check("t6 state", dbg_state, ST_IDLE);
        frame_start();
        send_line(4, 8'h90);
        frame_end();
        verify("t6_off", 0);

        // Frame counter wraps from 255 back to 0.
        capture_en = 1'b1;
        begin
            int n;
            n = 256 - int'(exp_frames);
            for (int k = 0; k < n; k++) begin
                frame_start();
                frame_end();
            end
            verify("t6_wrap", n);
            exp_frames = exp_frames + 8'(n);
        end
        check("t6 frame_cnt_wrap", frame_cnt, exp_frames);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
